// File: rtl/death_pkg.sv
// Shared types and constants for the death-screen overlay controller.
package death_pkg;

  typedef enum logic [2:0] {
    PLAY     = 3'd0,
    FADE_IN  = 3'd1,
    ARMING   = 3'd2,
    SHOW     = 3'd3,
    PRESSED  = 3'd4,
    FADE_OUT = 3'd5
  } ctrl_state_t;

  localparam logic [3:0] FADE_MAX = 4'hF;

  // Respawn button rectangle, inclusive edges, in screen pixels.
  localparam logic [9:0] BTN_X0_DEF = 10'd160;
  localparam logic [9:0] BTN_X1_DEF = 10'd479;
  localparam logic [9:0] BTN_Y0_DEF = 10'd288;
  localparam logic [9:0] BTN_Y1_DEF = 10'd327;

  localparam int unsigned DIV_W = 6;

endpackage

// File: rtl/frame_tick_div.sv
// Counts enable pulses modulo i_mod; o_tick marks the pulse that completes a period.
module frame_tick_div #(
  parameter int unsigned W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_mod,
  output logic         o_tick
);

  logic [W-1:0] r_count;
  logic         w_tick;

  assign w_tick = i_en && (r_count == i_mod - W'(1));
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_tick ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/death_screen_ctrl.sv
// Game-over overlay sequencer: freeze, fade in, arm, track the Respawn button,
// fade out and issue a one-cycle respawn pulse.
module death_screen_ctrl
  import death_pkg::*;
#(
  parameter int unsigned FADE_FRAMES = 2,
  parameter int unsigned ARM_FRAMES  = 30,
  parameter logic [9:0]  BTN_X0      = BTN_X0_DEF,
  parameter logic [9:0]  BTN_X1      = BTN_X1_DEF,
  parameter logic [9:0]  BTN_Y0      = BTN_Y0_DEF,
  parameter logic [9:0]  BTN_Y1      = BTN_Y1_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       player_dead,
  input  logic [6:0] score_in,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_left,
  output logic       overlay_en,
  output logic [3:0] fade_level,
  output logic [6:0] score_latched,
  output logic       btn_hover,
  output logic       btn_pressed,
  output logic       game_freeze,
  output logic       respawn
);

  ctrl_state_t      r_state, w_next;
  logic [3:0]       r_fade, w_fade_nxt;
  logic [6:0]       r_score;
  logic             r_overlay_en, r_freeze, r_hover, r_pressed, r_respawn;
  logic             r_mouse_prev, r_arm_done, w_arm_done_nxt;
  logic             w_latch, w_respawn_nxt;
  logic             w_hit, w_rise, w_fall;
  logic             w_tick, w_div_en, w_div_clr;
  logic [DIV_W-1:0] w_div_mod;

  assign w_hit  = (mouse_x >= BTN_X0) && (mouse_x <= BTN_X1) &&
                  (mouse_y >= BTN_Y0) && (mouse_y <= BTN_Y1);
  assign w_rise = mouse_left && !r_mouse_prev;
  assign w_fall = !mouse_left && r_mouse_prev;

  // One divider serves both fade and arm phases; it restarts on every state change.
  assign w_div_en  = frame_start && (r_state inside {FADE_IN, ARMING, FADE_OUT});
  assign w_div_clr = (w_next != r_state);
  assign w_div_mod = (r_state == ARMING) ? DIV_W'(ARM_FRAMES) : DIV_W'(FADE_FRAMES);

  frame_tick_div #(.W(DIV_W)) u_frame_div (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_en    (w_div_en),
    .i_clr   (w_div_clr),
    .i_mod   (w_div_mod),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_next         = r_state;
    w_fade_nxt     = r_fade;
    w_latch        = 1'b0;
    w_respawn_nxt  = 1'b0;
    w_arm_done_nxt = r_arm_done;
    case (r_state)
      PLAY: begin
        if (player_dead) begin
          w_next     = FADE_IN;
          w_latch    = 1'b1;
          w_fade_nxt = '0;
        end
      end
      FADE_IN: begin
        if (w_tick) begin
          w_fade_nxt = r_fade + 4'd1;
          if (r_fade == FADE_MAX - 4'd1) begin
            w_next         = ARMING;
            w_arm_done_nxt = 1'b0;
          end
        end
      end
      ARMING: begin
        // A button still held when the arm period ends must be released first.
        if (w_tick || r_arm_done) begin
          if (!mouse_left) w_next = SHOW;
          else             w_arm_done_nxt = 1'b1;
        end
      end
      SHOW: begin
        if (w_rise && w_hit) w_next = PRESSED;
      end
      PRESSED: begin
        if (w_fall) w_next = w_hit ? FADE_OUT : SHOW;
      end
      FADE_OUT: begin
        if (w_tick) begin
          w_fade_nxt = r_fade - 4'd1;
          if (r_fade == 4'd1) begin
            w_next        = PLAY;
            w_respawn_nxt = 1'b1;
          end
        end
      end
      default: w_next = PLAY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= PLAY;
      r_fade       <= '0;
      r_score      <= '0;
      r_overlay_en <= 1'b0;
      r_freeze     <= 1'b0;
      r_hover      <= 1'b0;
      r_pressed    <= 1'b0;
      r_respawn    <= 1'b0;
      r_mouse_prev <= 1'b0;
      r_arm_done   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fade       <= w_fade_nxt;
      if (w_latch) r_score <= score_in;
      r_overlay_en <= (w_next != PLAY);
      r_freeze     <= (w_next != PLAY);
      r_hover      <= w_hit && ((w_next == SHOW) || (w_next == PRESSED));
      r_pressed    <= w_hit && (w_next == PRESSED);
      r_respawn    <= w_respawn_nxt;
      r_mouse_prev <= mouse_left;
      r_arm_done   <= w_arm_done_nxt;
    end
  end

  assign overlay_en    = r_overlay_en;
  assign fade_level    = r_fade;
  assign score_latched = r_score;
  assign btn_hover     = r_hover;
  assign btn_pressed   = r_pressed;
  assign game_freeze   = r_freeze;
  assign respawn       = r_respawn;

endmodule

// File: tb/tb_death_screen_ctrl.sv
// Scoreboard bench for death_screen_ctrl: a frame-counting reference model
// predicts every cycle's outputs; a monitor pops and compares after each edge.
module tb_death_screen_ctrl;

  localparam int FF = 2;
  localparam int AF = 30;

  localparam int P_PLAY = 10, P_FIN = 11, P_ARM = 12, P_SHOW = 13, P_PRS = 14, P_FOUT = 15;

  typedef struct packed {
    logic       ov;
    logic [3:0] fade;
    logic [6:0] score;
    logic       hov;
    logic       prs;
    logic       frz;
    logic       rsp;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       player_dead = 1'b0;
  logic [6:0] score_in = '0;
  logic [9:0] mouse_x = '0;
  logic [9:0] mouse_y = '0;
  logic       mouse_left = 1'b0;
  logic       overlay_en, btn_hover, btn_pressed, game_freeze, respawn;
  logic [3:0] fade_level;
  logic [6:0] score_latched;

  death_screen_ctrl #(
    .FADE_FRAMES (FF),
    .ARM_FRAMES  (AF),
    .BTN_X0      (10'd160),
    .BTN_X1      (10'd479),
    .BTN_Y0      (10'd288),
    .BTN_Y1      (10'd327)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_start   (frame_start),
    .player_dead   (player_dead),
    .score_in      (score_in),
    .mouse_x       (mouse_x),
    .mouse_y       (mouse_y),
    .mouse_left    (mouse_left),
    .overlay_en    (overlay_en),
    .fade_level    (fade_level),
    .score_latched (score_latched),
    .btn_hover     (btn_hover),
    .btn_pressed   (btn_pressed),
    .game_freeze   (game_freeze),
    .respawn       (respawn)
  );

  always #5 Clk = ~Clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t m_last;
  int   m_phase = P_PLAY;
  int   m_frames = 0;
  logic [6:0] m_score = '0;
  logic m_prev = 1'b0;
  int   exp_respawns = 0;
  int   obs_respawns = 0;
  logic [9:0] cur_x = 10'd320;
  logic [9:0] cur_y = 10'd300;

  function automatic logic in_btn(input logic [9:0] x, input logic [9:0] y);
    return (x >= 160) && (x <= 479) && (y >= 288) && (y <= 327);
  endfunction

  function automatic logic rfs();
    return ($urandom_range(0, 2) == 0);
  endfunction

  // Reference: phases are timed by counting frames since phase entry; the
  // fade level is derived from that count rather than stepped.
  task automatic model_step(input logic fs, input logic dead, input logic [6:0] sc,
                            input logic [9:0] mx, input logic [9:0] my, input logic ml,
                            output exp_t e);
    logic hit, rise, fall, rsp;
    hit  = in_btn(mx, my);
    rise = ml && !m_prev;
    fall = !ml && m_prev;
    rsp  = 1'b0;
    case (m_phase)
      P_PLAY: if (dead) begin m_score = sc; m_phase = P_FIN; m_frames = 0; end
      P_FIN: begin
        if (fs) m_frames++;
        if (m_frames == 15 * FF) begin m_phase = P_ARM; m_frames = 0; end
      end
      P_ARM: begin
        if (fs) m_frames++;
        if (m_frames >= AF && !ml) m_phase = P_SHOW;
      end
      P_SHOW: if (rise && hit) m_phase = P_PRS;
      P_PRS: if (fall) begin
        if (hit) begin m_phase = P_FOUT; m_frames = 0; end
        else m_phase = P_SHOW;
      end
      P_FOUT: begin
        if (fs) m_frames++;
        if (m_frames == 15 * FF) begin m_phase = P_PLAY; rsp = 1'b1; exp_respawns++; end
      end
      default: m_phase = P_PLAY;
    endcase
    m_prev = ml;
    e.ov    = (m_phase != P_PLAY);
    e.frz   = (m_phase != P_PLAY);
    e.score = m_score;
    e.rsp   = rsp;
    e.hov   = hit && (m_phase == P_SHOW || m_phase == P_PRS);
    e.prs   = hit && (m_phase == P_PRS);
    if (m_phase == P_FIN)       e.fade = 4'(m_frames / FF);
    else if (m_phase == P_FOUT) e.fade = 4'(15 - m_frames / FF);
    else if (m_phase == P_PLAY) e.fade = 4'd0;
    else                        e.fade = 4'd15;
  endtask

  task automatic drive(input logic fs, input logic dead, input logic [6:0] sc,
                       input logic [9:0] mx, input logic [9:0] my, input logic ml);
    exp_t e;
    @(negedge Clk);
    frame_start = fs;
    player_dead = dead;
    score_in    = sc;
    mouse_x     = mx;
    mouse_y     = my;
    mouse_left  = ml;
    model_step(fs, dead, sc, mx, my, ml, e);
    exp_q.push_back(e);
    m_last = e;
  endtask

  task automatic hold(input int n, input logic ml, input logic use_fs);
    for (int i = 0; i < n; i++) drive(use_fs ? rfs() : 1'b0, 1'b0, 7'd0, cur_x, cur_y, ml);
  endtask

  task automatic run_until(input int ph, input logic ml);
    for (int i = 0; i < 5000 && m_phase != ph; i++) drive(rfs(), 1'b0, 7'd0, cur_x, cur_y, ml);
    checks++;
    if (m_phase != ph) begin
      errors++;
      $display("FAIL phase_bound: model phase %0d, required %0d", m_phase, ph);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({overlay_en, fade_level, score_latched, btn_hover, btn_pressed, game_freeze, respawn} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b fade=%0d score=%0d hov=%b prs=%b frz=%b rsp=%b, required all 0",
               overlay_en, fade_level, score_latched, btn_hover, btn_pressed, game_freeze, respawn);
    end
    repeat (3) @(negedge Clk);
    Reset_n  = 1'b1;
    m_phase  = P_PLAY;
    m_frames = 0;
    m_score  = '0;
    m_prev   = 1'b0;
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got.ov = overlay_en;  got.fade = fade_level; got.score = score_latched;
        got.hov = btn_hover;  got.prs = btn_pressed; got.frz = game_freeze; got.rsp = respawn;
        if (respawn === 1'b1) obs_respawns++;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got ov=%b fade=%0d score=%0d hov=%b prs=%b frz=%b rsp=%b, required ov=%b fade=%0d score=%0d hov=%b prs=%b frz=%b rsp=%b",
                   $time, got.ov, got.fade, got.score, got.hov, got.prs, got.frz, got.rsp,
                   e.ov, e.fade, e.score, e.hov, e.prs, e.frz, e.rsp);
        end
      end
    end
  end

  initial begin : stimulus
    int xs[10] = '{150, 159, 160, 161, 320, 478, 479, 480, 700, 0};
    int ys[9]  = '{100, 287, 288, 289, 300, 326, 327, 328, 500};
    logic ml;

    do_reset();
    hold(5, 1'b0, 1'b1);

    // Death with score 42, full fade-in, then a click during arming.
    cur_x = 10'd320; cur_y = 10'd300;
    drive(1'b0, 1'b1, 7'd42, cur_x, cur_y, 1'b0);
    run_until(P_ARM, 1'b0);
    hold(4, 1'b1, 1'b0);
    hold(4, 1'b0, 1'b0);
    run_until(P_SHOW, 1'b0);

    // Press inside, drag out and back, drag out and release: cancelled.
    hold(3, 1'b1, 1'b1);
    cur_x = 10'd100; hold(3, 1'b1, 1'b1);
    cur_x = 10'd320; hold(3, 1'b1, 1'b1);
    cur_x = 10'd100; hold(2, 1'b1, 1'b1);
    hold(3, 1'b0, 1'b1);
    cur_x = 10'd159; cur_y = 10'd300; hold(3, 1'b0, 1'b1);
    cur_x = 10'd320; cur_y = 10'd328; hold(3, 1'b0, 1'b1);

    // Second death while showing must not re-latch.
    drive(1'b1, 1'b1, 7'd7, cur_x, cur_y, 1'b0);
    hold(3, 1'b0, 1'b1);

    // Corner press/release, fade out, reset at fade level 8.
    cur_x = 10'd160; cur_y = 10'd288; hold(3, 1'b1, 1'b1);
    cur_x = 10'd479; cur_y = 10'd327; hold(2, 1'b1, 1'b1);
    hold(1, 1'b0, 1'b1);
    for (int i = 0; i < 2000 && !(m_phase == P_FOUT && m_last.fade == 4'd8); i++)
      drive(rfs(), 1'b0, 7'd0, cur_x, cur_y, 1'b0);
    do_reset();
    hold(4, 1'b0, 1'b1);

    // Button held through death and past the arm period.
    cur_x = 10'd320; cur_y = 10'd300;
    drive(1'b0, 1'b1, 7'd99, cur_x, cur_y, 1'b1);
    run_until(P_ARM, 1'b1);
    for (int i = 0; i < 2000 && m_frames < AF + 5; i++) drive(rfs(), 1'b0, 7'd0, cur_x, cur_y, 1'b1);
    hold(2, 1'b1, 1'b1);
    hold(2, 1'b0, 1'b1);
    hold(2, 1'b1, 1'b1);
    hold(1, 1'b0, 1'b1);
    run_until(P_PLAY, 1'b0);
    hold(4, 1'b0, 1'b1);

    // Randomised traffic around the button edges.
    ml = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) ml = ~ml;
      if ($urandom_range(0, 3) == 0) begin
        cur_x = 10'(xs[$urandom_range(0, 9)]);
        cur_y = 10'(ys[$urandom_range(0, 8)]);
      end
      drive($urandom_range(0, 1) == 0, $urandom_range(0, 39) == 0,
            7'($urandom_range(0, 127)), cur_x, cur_y, ml);
    end

    repeat (2) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    checks++;
    if (obs_respawns != exp_respawns) begin
      errors++;
      $display("FAIL respawn_count: got %0d pulses, required %0d", obs_respawns, exp_respawns);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/death_screen_ctrl.md
Name: death_screen_ctrl

Overview:
Sequences the game-over overlay. On a player-death event it freezes gameplay, latches the score, and fades the death overlay in frame by frame. It then arms and tracks the mouse against the on-screen Respawn button. A completed click fades the overlay out and issues a one-cycle respawn pulse. It sits between game logic, the mouse/PS2 front end and the death-overlay colour generator / final pixel mux.

Parameters:
FADE_FRAMES, 2, frames per fade_level step (1..15)
ARM_FRAMES, 30, frames after full fade-in before clicks are accepted (1..63)
BTN_X0, 160, button left edge, inclusive, pixels
BTN_X1, 479, button right edge, inclusive
BTN_Y0, 288, button top edge, inclusive
BTN_Y1, 327, button bottom edge, inclusive

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of each VGA frame
player_dead  in  1  one-cycle death event from game logic
score_in  in  7  live score (0..99)
mouse_x  in  10  cursor x, pixels
mouse_y  in  10  cursor y, pixels
mouse_left  in  1  left button level, 1 = held
overlay_en  out  1  select death overlay in pixel mux
fade_level  out  4  overlay blend weight, 0 = transparent, 15 = opaque
score_latched  out  7  score captured at death, feeds overlay digits
btn_hover  out  1  cursor inside button and controller armed
btn_pressed  out  1  button currently held down (draw darker shade)
game_freeze  out  1  halt player/arrow/entity updates
respawn  out  1  one-cycle pulse to reset the player

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=PLAY. All outputs 0. Frame counter and arm counter cleared.
- All outputs are registered. Transitions take effect on the cycle after the triggering input.
- States: PLAY, FADE_IN, ARMING, SHOW, PRESSED, FADE_OUT.
- PLAY:
  - overlay_en=0, game_freeze=0.
  - player_dead -> FADE_IN: score_latched<=score_in, fade_level<=0, frame counter<=0.
  - score_in >99 is latched as-is; digit clamping is the overlay's job.
- FADE_IN:
  - overlay_en=1, game_freeze=1.
  - Each frame_start increments frame counter. When the counter reaches FADE_FRAMES-1 on a frame_start, clear it and fade_level++.
  - When fade_level becomes 15 -> ARMING, arm counter<=0.
- ARMING:
  - Each frame_start increments the arm counter.
  - Exits to SHOW on the frame_start where the count reaches ARM_FRAMES-1 AND mouse_left=0.
  - If mouse_left=1 at that point, remain in ARMING until the first cycle with mouse_left=0. This rejects a click held through the death.
- hit = (BTN_X0<=mouse_x<=BTN_X1) && (BTN_Y0<=mouse_y<=BTN_Y1). Unsigned 10-bit compares, inclusive edges.
- btn_hover = hit in SHOW/PRESSED only, else 0.
- SHOW: mouse_left rising edge (registered previous sample) with hit -> PRESSED. A rising edge outside is ignored.
- PRESSED:
  - btn_pressed=1 while hit.
  - mouse_left falling with hit -> FADE_OUT, frame counter<=0.
  - Falling without hit -> SHOW (click cancelled).
  - Drag out and back in while held stays in PRESSED.
- FADE_OUT: mirror of FADE_IN, fade_level decrements. When fade_level reaches 0 -> PLAY, and respawn=1 for exactly that cycle. game_freeze drops the same cycle.
- player_dead in any state other than PLAY is ignored (no re-latch, no restart).
- frame_start and a mouse edge in the same cycle: both are processed. Fade/arm counting applies only in its own states, so there is no conflict.
- Reset mid-fade or mid-press: immediate return to PLAY, no respawn pulse.
- Frame counter is 4 bits; arm counter is 6 bits. No wrap is reachable within the parameter ranges.

Decomposition:
- Package death_pkg holds:
  - state enum typedef (ctrl_state_t, 3 bits);
  - button rectangle defaults;
  - FADE_MAX=4'hF.
- One sub-module, frame_tick_div: counts frame_start pulses modulo N with a clear input and a tick output. It is instantiated once and shared by the fade and arm phases.

Test Plan:
- Reset, then player_dead with score_in=42 and FADE_FRAMES=2 -> score_latched=42, fade_level rises 0..15 one step per 2 frames (30 frames total), game_freeze=1 throughout.
- After full fade-in, ARM_FRAMES=30: a click at (320,300) during arming -> ignored, no PRESSED. Click after frame 30 -> btn_pressed=1. Release inside -> FADE_OUT; respawn pulses exactly 1 cycle when fade_level hits 0.
- Mouse held through death and arming -> stays in ARMING past frame 30 until release. A new press/release at (160,288) then (479,327) edges -> accepted.
- Press at (320,300), drag to (100,300), release -> back to SHOW, no respawn. btn_hover=0 at (159,300) and (320,328).
- Second player_dead during SHOW with score_in=7 -> score_latched stays 42, state unchanged.
- Reset_n asserted mid FADE_OUT (fade_level=8) -> all outputs 0 asynchronously, no respawn pulse.
